// File: rtl/hh_step_scheduler_if.sv
// Handshake bundle between the step scheduler, the shared HH datapath and the STDP unit.
// The master modport is the scheduler side; the slave modport is the datapath/STDP side.
interface hh_step_scheduler_if #(
  parameter int unsigned IDX_W = 2
);
  logic             dp_start;
  logic [IDX_W-1:0] dp_idx;
  logic             dp_done;
  logic             dp_spike;
  logic             stdp_req;
  logic [IDX_W-1:0] stdp_idx;
  logic             stdp_ack;

  modport master (
    output dp_start, dp_idx, stdp_req, stdp_idx,
    input  dp_done, dp_spike, stdp_ack
  );

  modport slave (
    input  dp_start, dp_idx, stdp_req, stdp_idx,
    output dp_done, dp_spike, stdp_ack
  );
endinterface

// File: rtl/hh_step_scheduler.sv
// Per-tick sequencer: one shared HH datapath op per neuron, then one STDP request per spiking neuron.
// Optional refractory skipping is enabled by defining HH_SCHED_REFRACT_EN.
module hh_step_scheduler #(
  parameter int unsigned NUM_NEURONS   = 4,
  parameter int unsigned IDX_W         = 2,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned STEP_W        = 16,
  parameter int unsigned REFRACT_STEPS = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable_i,
  input  logic                   tick_i,
  input  logic                   clear_err_i,
  hh_step_scheduler_if.master    bus,
  output logic                   busy_o,
  output logic                   step_done_o,
  output logic [NUM_NEURONS-1:0] spike_vec_o,
  output logic [STEP_W-1:0]      step_count_o,
  output logic                   overrun_o,
  output logic                   dp_timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SCAN,
    S_STDP_REQ,
    S_COMMIT
  } state_t;

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_NEURONS-1:0] spike_buf_q, spike_buf_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_NEURONS-1:0] spike_vec_q, spike_vec_d;
  logic [STEP_W-1:0]      step_count_q, step_count_d;
  logic                   overrun_q, overrun_d;
  logic                   tmo_q, tmo_d;
  logic                   set_tmo;
  logic                   step_done_q, step_done_d;
  logic                   dp_start_q, dp_start_d;
  logic [IDX_W-1:0]       dp_idx_q;
  logic                   stdp_req_q;
  logic [IDX_W-1:0]       stdp_idx_q;
  logic                   busy_q;

  // skip_cur: current ISSUE slot is refractory; launch_nxt: neuron entering ISSUE may launch.
  logic                   skip_cur;
  logic                   launch_nxt;

`ifdef HH_SCHED_REFRACT_EN
  localparam int unsigned RC_W = (REFRACT_STEPS < 1) ? 1 : $clog2(REFRACT_STEPS + 1);

  logic [RC_W-1:0] refr_q [NUM_NEURONS];
  logic [RC_W-1:0] refr_d [NUM_NEURONS];

  always_comb begin
    skip_cur   = (state_q == S_ISSUE) && (refr_q[idx_q] != '0);
    launch_nxt = (refr_q[idx_d] == '0);
  end

  always_comb begin
    for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
      refr_d[n] = refr_q[n];
    end
    if (skip_cur) begin
      refr_d[idx_q] = refr_q[idx_q] - RC_W'(1);
    end
    if (state_q == S_COMMIT) begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
        if (spike_buf_q[n]) begin
          refr_d[n] = RC_W'(REFRACT_STEPS);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
        refr_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
        refr_q[n] <= refr_d[n];
      end
    end
  end
`else
  logic unused_refract;
  assign unused_refract = (REFRACT_STEPS != 0);

  always_comb begin
    skip_cur   = 1'b0;
    launch_nxt = 1'b1;
  end
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    spike_buf_d  = spike_buf_q;
    timer_d      = timer_q;
    spike_vec_d  = spike_vec_q;
    step_count_d = step_count_q;
    step_done_d  = 1'b0;
    set_tmo      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tick_i && enable_i) begin
          state_d     = S_ISSUE;
          idx_d       = '0;
          spike_buf_d = '0;
        end
      end

      S_ISSUE: begin
        if (skip_cur) begin
          spike_buf_d[idx_q] = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_SCAN;
            idx_d   = '0;
          end else begin
            state_d = S_ISSUE;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end

      S_WAIT: begin
        // A timeout completes the slot exactly like dp_done, but with no spike.
        if (bus.dp_done || (timer_q == TMR_LAST)) begin
          if (bus.dp_done) begin
            spike_buf_d[idx_q] = bus.dp_spike;
          end else begin
            spike_buf_d[idx_q] = 1'b0;
            set_tmo            = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_SCAN;
            idx_d   = '0;
          end else begin
            state_d = S_ISSUE;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_SCAN: begin
        if (spike_buf_q[idx_q]) begin
          state_d = S_STDP_REQ;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_COMMIT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_STDP_REQ: begin
        if (bus.stdp_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_COMMIT;
            idx_d   = '0;
          end else begin
            state_d = S_SCAN;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end

      S_COMMIT: begin
        spike_vec_d  = spike_buf_q;
        step_count_d = step_count_q + STEP_W'(1);
        step_done_d  = 1'b1;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky flags: a set in the same cycle as clear_err wins.
  always_comb begin
    overrun_d  = (overrun_q & ~clear_err_i) | (tick_i && (state_q != S_IDLE));
    tmo_d      = (tmo_q & ~clear_err_i) | set_tmo;
    dp_start_d = (state_d == S_ISSUE) && launch_nxt;
  end

  // Handshake outputs are registered from next-state so they align with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      spike_buf_q  <= '0;
      timer_q      <= '0;
      spike_vec_q  <= '0;
      step_count_q <= '0;
      overrun_q    <= 1'b0;
      tmo_q        <= 1'b0;
      step_done_q  <= 1'b0;
      dp_start_q   <= 1'b0;
      dp_idx_q     <= '0;
      stdp_req_q   <= 1'b0;
      stdp_idx_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      spike_buf_q  <= spike_buf_d;
      timer_q      <= timer_d;
      spike_vec_q  <= spike_vec_d;
      step_count_q <= step_count_d;
      overrun_q    <= overrun_d;
      tmo_q        <= tmo_d;
      step_done_q  <= step_done_d;
      dp_start_q   <= dp_start_d;
      dp_idx_q     <= idx_d;
      stdp_req_q   <= (state_d == S_STDP_REQ);
      stdp_idx_q   <= idx_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign bus.dp_start     = dp_start_q;
  assign bus.dp_idx       = dp_idx_q;
  assign bus.stdp_req     = stdp_req_q;
  assign bus.stdp_idx     = stdp_idx_q;
  assign busy_o           = busy_q;
  assign step_done_o      = step_done_q;
  assign spike_vec_o      = spike_vec_q;
  assign step_count_o     = step_count_q;
  assign overrun_o        = overrun_q;
  assign dp_timeout_err_o = tmo_q;

endmodule
